// File: rtl/clk_div_pkg.sv
// Shared types and sizing for the multi-channel clock divider.
// The ratio range is fixed here so the config struct has one width everywhere.
package clk_div_pkg;

    localparam int MAX_DIV = 64;
    localparam int DIV_W   = $clog2(MAX_DIV);

    typedef enum logic {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } div_mode_e;

    typedef struct packed {
        div_mode_e              mode;
        logic [DIV_W-1:0]       div_less_1;
    } div_cfg_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, output flop, active/pending config and a
// falling-edge bypass select that only changes while both clock sources are low.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter logic [DIV_W-1:0] RST_DIV_LESS_1 = '0
) (
    input  logic     refclk,
    input  logic     rst,
    input  logic     dft_en,
    input  logic     ch_en,
    input  logic     ch_bypass,
    input  logic     cfg_load,
    input  div_cfg_t cfg_new,
    output logic     cfg_pending,
    output logic     divclk,
    output logic     divpulse,
    output logic     upd_done
);

    localparam div_cfg_t RST_CFG = '{mode: TOGGLE, div_less_1: RST_DIV_LESS_1};

    logic             en_q;
    logic [DIV_W-1:0] cnt;
    logic             div_q;
    div_cfg_t         act_cfg;
    div_cfg_t         pend_cfg;
    logic             pending;
    logic             bypass_q;
    logic             sel_n;
    logic             divpulse_q;
    logic             upd_done_q;

    logic             terminal;
    logic             boundary;
    logic             apply;
    logic [DIV_W-1:0] cnt_nxt;
    logic             div_nxt;
    div_cfg_t         act_nxt;
    logic             bypass_nxt;
    logic             pending_nxt;
    logic             pulse_nxt;

    always_comb begin
        terminal    = en_q && (cnt == act_cfg.div_less_1);
        boundary    = !en_q || (terminal && ((act_cfg.mode == PULSE) || div_q));
        apply       = boundary && pending;

        cnt_nxt     = cnt;
        div_nxt     = div_q;
        act_nxt     = act_cfg;
        bypass_nxt  = bypass_q;
        pending_nxt = pending;

        if (apply) begin
            act_nxt = pend_cfg;
            cnt_nxt = '0;
            div_nxt = 1'b0;
        end else if (!ch_en || !en_q) begin
            // a channel that is (re)starting begins its first period from cnt 0
            cnt_nxt = '0;
            div_nxt = 1'b0;
        end else if (terminal) begin
            cnt_nxt = '0;
            div_nxt = (act_cfg.mode == TOGGLE) ? ~div_q : 1'b0;
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end

        // div_q is low after every boundary, so the select may change here
        if (boundary) begin
            bypass_nxt = ch_bypass;
        end

        if (cfg_load) begin
            pending_nxt = 1'b1;
        end else if (apply) begin
            pending_nxt = 1'b0;
        end

        // strobe is computed from next-cycle state so it lands in the terminal cycle itself
        pulse_nxt = ch_en && (bypass_nxt ||
                    ((cnt_nxt == act_nxt.div_less_1) && ((act_nxt.mode == PULSE) || div_nxt)));
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            en_q       <= 1'b0;
            cnt        <= '0;
            div_q      <= 1'b0;
            act_cfg    <= RST_CFG;
            pending    <= 1'b0;
            bypass_q   <= 1'b0;
            divpulse_q <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            en_q       <= ch_en;
            cnt        <= cnt_nxt;
            div_q      <= div_nxt;
            act_cfg    <= act_nxt;
            pending    <= pending_nxt;
            bypass_q   <= bypass_nxt;
            divpulse_q <= pulse_nxt;
            upd_done_q <= apply;
        end
    end

    always_ff @(posedge refclk) begin
        if (cfg_load) begin
            pend_cfg <= cfg_new;
        end
    end

    always_ff @(negedge refclk) begin
        if (rst) begin
            sel_n <= 1'b0;
        end else begin
            sel_n <= bypass_q;
        end
    end

    assign divclk      = (dft_en | sel_n) ? refclk : div_q;
    assign divpulse    = divpulse_q;
    assign upd_done    = upd_done_q;
    assign cfg_pending = pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-reconfigurable clock divider: shared config port
// decode and ready mux around NUM_CH independent channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int RST_DIV_LESS_1 = 0,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              dft_en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_bypass,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div_less_1,
    output logic [NUM_CH-1:0] divclk,
    output logic [NUM_CH-1:0] divpulse,
    output logic [NUM_CH-1:0] upd_done
);

    logic [NUM_CH-1:0] ch_pending;
    logic [NUM_CH-1:0] cfg_load;
    logic              sel_free;
    div_cfg_t          cfg_new;

    assign cfg_new = '{mode: div_mode_e'(cfg_mode), div_less_1: cfg_div_less_1};

    // an out-of-range channel index is accepted and dropped so the port never stalls
    always_comb begin
        sel_free = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                sel_free = ~ch_pending[i];
            end
        end
        cfg_ready = ~rst & sel_free;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_load[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .RST_DIV_LESS_1 (DIV_W'(RST_DIV_LESS_1))
        ) u_ch (
            .refclk      (refclk),
            .rst         (rst),
            .dft_en      (dft_en),
            .ch_en       (ch_en[g]),
            .ch_bypass   (ch_bypass[g]),
            .cfg_load    (cfg_load[g]),
            .cfg_new     (cfg_new),
            .cfg_pending (ch_pending[g]),
            .divclk      (divclk[g]),
            .divpulse    (divpulse[g]),
            .upd_done    (upd_done[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: divide, reconfigure, pulse mode, bypass,
// config back-pressure, reset with a pending update, and DFT override.
module tb_clk_div_multi;

    logic       refclk = 1'b0;
    logic       rst;
    logic       dft_en;
    logic [3:0] ch_en;
    logic [3:0] ch_bypass;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic       cfg_mode;
    logic [5:0] cfg_div_less_1;
    logic [3:0] divclk;
    logic [3:0] divpulse;
    logic [3:0] upd_done;

    int n_vec = 0;
    int n_err = 0;

    realtime last_edge = 0.0;
    realtime min_w     = 1000.0;
    bit      have_edge = 1'b0;
    bit      mon_en    = 1'b0;

    clk_div_multi #(
        .NUM_CH         (4),
        .RST_DIV_LESS_1 (0)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .dft_en         (dft_en),
        .ch_en          (ch_en),
        .ch_bypass      (ch_bypass),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_ch         (cfg_ch),
        .cfg_mode       (cfg_mode),
        .cfg_div_less_1 (cfg_div_less_1),
        .divclk         (divclk),
        .divpulse       (divpulse),
        .upd_done       (upd_done)
    );

    always #5 refclk = ~refclk;

    // narrowest high or low phase seen on channel 0 while the bypass switches
    always @(divclk[0]) begin
        if (mon_en) begin
            if (have_edge && (($realtime - last_edge) < min_w)) min_w = $realtime - last_edge;
            last_edge = $realtime;
            have_edge = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic fall();
        @(negedge refclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dft_en = 1'b0; ch_en = 4'b0; ch_bypass = 4'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_mode = 1'b0; cfg_div_less_1 = 6'd0;

        // reset state and DFT override during reset
        repeat (3) step();
        check_val("rst_ready",  cfg_ready, 0);
        check_val("rst_pulse",  divpulse,  0);
        check_val("rst_upd",    upd_done,  0);
        check_val("rst_divclk", divclk,    0);
        dft_en = 1'b1; #1;
        check_val("rst_dft_hi", divclk, 4'hF);
        fall();
        check_val("rst_dft_lo", divclk, 0);
        dft_en = 1'b0; #1;
        check_val("rst_divclk_lo", divclk, 0);

        // ch0/ch1 at d=0 toggle: period 2
        step();
        rst = 1'b0; ch_en = 4'b0011; #1;
        check_val("t1_ready", cfg_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_val("t1_divclk", divclk[1:0],   (k % 2 == 0) ? 2'b11 : 2'b00);
            check_val("t1_pulse",  divpulse[1:0], (k % 2 == 0) ? 2'b11 : 2'b00);
        end

        // ch1 -> d=2 toggle, written mid-period
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_div_less_1 = 6'd2; #1;
        check_val("t2_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0; #1;
        check_val("t2_stall", cfg_ready,   0);
        check_val("t2_pulse", divpulse[1], 1);
        check_val("t2_noupd", upd_done[1], 0);
        for (int j = 0; j < 12; j++) begin
            step();
            check_val("t2_divclk", divclk[1],   ((j % 6) >= 3) ? 1 : 0);
            check_val("t2_pulse6", divpulse[1], ((j % 6) == 5) ? 1 : 0);
            check_val("t2_upd",    upd_done[1], (j == 0) ? 1 : 0);
        end

        // ch2 PULSE d=4, configured while disabled
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_mode = 1'b1; cfg_div_less_1 = 6'd4;
        step();
        cfg_valid = 1'b0; #1;
        check_val("t3_ready", cfg_ready,   0);
        check_val("t3_noupd", upd_done[2], 0);
        step();
        check_val("t3_upd", upd_done[2], 1);
        ch_en = 4'b0111;
        for (int j = 0; j < 10; j++) begin
            step();
            check_val("t3_pulse",  divpulse[2], ((j % 5) == 4) ? 1 : 0);
            check_val("t3_divclk", divclk[2],   0);
        end

        // ch0 bypass on/off requested off-boundary
        mon_en = 1'b1;
        step();
        check_val("t4_pre", divclk[0], 0);
        ch_bypass = 4'b0001;
        step();
        check_val("t4_wait_pulse", divpulse[0], 1);
        fall();
        check_val("t4_wait_hold", divclk[0], 1);
        step();
        check_val("t4_sw_lo",    divclk[0],   0);
        check_val("t4_sw_pulse", divpulse[0], 1);
        fall();
        check_val("t4_sw_fall", divclk[0], 0);
        step();
        check_val("t4_byp_hi",    divclk[0],   1);
        check_val("t4_byp_pulse", divpulse[0], 1);
        fall();
        check_val("t4_byp_lo", divclk[0], 0);
        step();
        check_val("t4_byp_hi2",    divclk[0],   1);
        check_val("t4_byp_pulse2", divpulse[0], 1);
        ch_bypass = 4'b0000;
        step();
        check_val("t4_byp_held",  divclk[0],   1);
        check_val("t4_byp_pulse3", divpulse[0], 1);
        step();
        check_val("t4_exit_hi",    divclk[0],   1);
        check_val("t4_exit_pulse", divpulse[0], 0);
        fall();
        check_val("t4_exit_lo", divclk[0], 0);
        step();
        check_val("t4_div_hi",    divclk[0],   1);
        check_val("t4_div_pulse", divpulse[0], 1);
        fall();
        check_val("t4_div_hold", divclk[0], 1);
        mon_en = 1'b0;

        // back-to-back requests to ch1; ch3 accepted while ch1 stalls
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_div_less_1 = 6'd1; #1;
        check_val("t5_ready1", cfg_ready, 1);
        step();
        cfg_div_less_1 = 6'd0; #1;
        check_val("t5_stall", cfg_ready, 0);
        cfg_ch = 2'd3; cfg_mode = 1'b1; cfg_div_less_1 = 6'd1; #1;
        check_val("t5_other", cfg_ready, 1);
        step();
        cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_div_less_1 = 6'd0; #1;
        check_val("t5_stall2", cfg_ready,   0);
        check_val("t5_ch3_wait", upd_done[3], 0);
        step();
        check_val("t5_ch3_upd", upd_done[3], 1);
        check_val("t5_stall3",  cfg_ready,   0);
        step();
        check_val("t5_ch3_once", upd_done[3], 0);
        check_val("t5_stall4",   cfg_ready,   0);
        check_val("t5_ch1_wait", upd_done[1], 0);
        step();
        check_val("t5_ch1_upd", upd_done[1], 1);
        check_val("t5_ready2",  cfg_ready,   1);
        step();
        cfg_valid = 1'b0; #1;
        check_val("t5_stall5",  cfg_ready,   0);
        check_val("t5_ch1_no",  upd_done[1], 0);
        check_val("t5_d1_lo",   divclk[1],   0);
        step();
        check_val("t5_d1_hi",   divclk[1],   1);
        check_val("t5_ch1_no2", upd_done[1], 0);
        step();
        check_val("t5_d1_hi2",  divclk[1],   1);
        check_val("t5_ch1_no3", upd_done[1], 0);
        step();
        check_val("t5_ch1_upd2", upd_done[1], 1);
        check_val("t5_d0_lo",    divclk[1],   0);

        // reset with an update pending on ch1
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_div_less_1 = 6'd2; #1;
        check_val("t6_ready", cfg_ready, 1);
        step();
        cfg_valid = 1'b0; #1;
        check_val("t6_pending", cfg_ready, 0);
        rst = 1'b1;
        step();
        check_val("t6_rst_ready",  cfg_ready, 0);
        check_val("t6_rst_pulse",  divpulse,  0);
        check_val("t6_rst_upd",    upd_done,  0);
        check_val("t6_rst_divclk", divclk,    0);
        step();
        rst = 1'b0; #1;
        check_val("t6_dropped", cfg_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val("t6_divclk", divclk[1],   (k % 2 == 0) ? 1 : 0);
            check_val("t6_noupd",  upd_done[1], 0);
        end

        // DFT override in normal operation
        dft_en = 1'b1; #1;
        check_val("t7_dft_hi", divclk, 4'hF);
        fall();
        check_val("t7_dft_lo", divclk, 0);
        dft_en = 1'b0;

        check_val("t4_edges_seen", have_edge, 1);
        check_val("t4_min_width", (min_w >= 5.0) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-reconfigurable clock divider that generalises the single-channel configurable divider. Each of NUM_CH channels divides refclk by a per-channel ratio, produces a 50%-duty divided clock or a one-cycle clock-enable strobe, and switches between divided and bypassed refclk glitch-free. Ratio and mode updates are taken through a shared valid/ready port and applied only at a period boundary, so downstream logic never sees a runt pulse. The block sits in the clock/reset subsystem and feeds peripheral and debug clock domains.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- MAX_DIV, 64, ratio range; DIV_W = $clog2(MAX_DIV)
- CH_W, derived: max(1, $clog2(NUM_CH))
- RST_DIV_LESS_1, 0, per-channel ratio field after reset
- refclk  in  1  sole clock; rising edge for all state, plus one falling-edge select flop per channel
- rst  in  1  reset; synchronous, active-high
- dft_en  in  1  combinationally forces every divclk to refclk
- ch_en  in  NUM_CH  per-channel run enable
- ch_bypass  in  NUM_CH  1 = request refclk on divclk, 0 = divided clock
- cfg_valid  in  1  update request
- cfg_ready  out  1  request accepted when valid & ready
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  1  0 = TOGGLE, 1 = PULSE
- cfg_div_less_1  in  DIV_W  new ratio field d
- divclk  out  NUM_CH  divided or bypassed clock
- divpulse  out  NUM_CH  one-refclk-cycle strobe, once per output period
- upd_done  out  NUM_CH  one-cycle pulse when a pending update is applied

## Operation
- Per channel: counter cnt (DIV_W), output flop div_q, active cfg (mode, d), pending cfg plus pending flag, and bypass_q.
- TOGGLE: cnt counts 0..d. At terminal (cnt==d): cnt←0 and div_q toggles. Period is 2(d+1) refclk cycles at 50% duty. divpulse=1 in the terminal cycle when div_q==1.
- PULSE: cnt counts 0..d. divpulse=1 when cnt==d, giving a period of d+1 cycles; d=0 gives divpulse high every cycle. div_q is held 0.
- Boundary: in TOGGLE, terminal with div_q==1; in PULSE, every terminal. A disabled channel is at a boundary every cycle.
- ch_en=0: cnt, div_q and divpulse are held 0. After ch_en rises, the first terminal occurs d+1 cycles later.
- Config port: cfg_ready = ~rst & ~pending[cfg_ch]. On accept, the values load into the pending register and the pending flag sets.
- At a boundary with pending set: active cfg←pending, cnt←0, div_q←0, pending clears, and upd_done pulses for one cycle.
- Apply and a new accept on the same channel cannot coincide, because ready is low during the apply cycle; the next request is accepted on the following cycle.
- Bypass: bypass_q←ch_bypass only at a boundary, where div_q is 0 by construction.
  - sel_n captures bypass_q on the falling edge of refclk.
  - divclk = (dft_en | sel_n) ? refclk : div_q.
  - The switch occurs while refclk is low and div_q is low, so it is glitch-free in both directions.
- While bypassed and enabled, divpulse=1 every cycle.

## Timing
- Reset values: cnt 0, div_q 0, d=RST_DIV_LESS_1, mode TOGGLE, pending 0, bypass_q 0, sel_n 0.
- Outputs during reset: divpulse 0, upd_done 0, cfg_ready 0, divclk = dft_en ? refclk : 0.
- rst must be held for ≥1 full refclk cycle so that the falling-edge flop also resets.
- Reset mid-period or with an update pending: all state returns to reset values and the pending update is discarded.
- divpulse and upd_done are registered outputs, with no combinational path from the config inputs.
- Update latency: accept to apply is at most one output period plus 1 cycle. A disabled channel applies the update in the cycle after accept.
- Bypass latency: from a boundary to the divclk switch is half a refclk cycle (next falling edge).
- dft_en acts immediately and combinationally, without synchronisation; it is static in DFT mode.

## Structure
- Package clk_div_pkg:
  - typedef enum logic {TOGGLE, PULSE} div_mode_e
  - typedef struct packed {div_mode_e mode; logic [DIV_W-1:0] div_less_1;} div_cfg_t
- Sub-module clk_div_ch: one channel, instantiated NUM_CH times by generate.
- The top level holds only cfg_ch decode and the cfg_ready mux.

## Test plan
- Reset, ch0 enabled, d=0, TOGGLE -> divclk period 2 cycles; divpulse every 2nd cycle.
- Write ch1 d=2, TOGGLE, mid-period -> current period completes, upd_done pulses once, then divclk period 6 with 3 high/3 low; cfg_ready low until apply.
- ch2 PULSE, d=4 -> divpulse once per 5 cycles; divclk constant 0.
- Toggle ch_bypass on ch0 at arbitrary cycles -> switch only at boundary; no high or low phase shorter than half a refclk period; while bypassed, divpulse constant 1.
- Back-to-back cfg_valid to the same channel -> second request stalls until upd_done; a request to another channel is accepted in the same cycle.
- Assert rst with an update pending; separately, drive dft_en=1 -> pending dropped and reset values restored; divclk follows refclk on all channels.
